// File: rtl/seg7_word_reader.sv
// Collects a frame of active-low 7-segment digit codes, least-significant first,
// and publishes the decoded hex word once the last digit of the frame arrives.
module seg7_word_reader #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic [0:6]            seg_in,
    input  logic                  seg_valid,
    input  logic                  seg_first,
    output logic [4*DIGITS-1:0]   word,
    output logic                  word_valid,
    output logic                  err,
    output logic                  abort,
    output logic                  busy
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Returns {illegal, nibble}; unknown codes decode to nibble 0 with illegal set.
    function automatic logic [4:0] seg_decode(input logic [6:0] code);
        logic [4:0] res;
        case (code)
            7'b0000001: res = 5'b0_0000;
            7'b1001111: res = 5'b0_0001;
            7'b0010010: res = 5'b0_0010;
            7'b0000110: res = 5'b0_0011;
            7'b1001100: res = 5'b0_0100;
            7'b0100100: res = 5'b0_0101;
            7'b0100000: res = 5'b0_0110;
            7'b0001111: res = 5'b0_0111;
            7'b0000000: res = 5'b0_1000;
            7'b0000100: res = 5'b0_1001;
            7'b0001000: res = 5'b0_1010;
            7'b1100000: res = 5'b0_1011;
            7'b0110001: res = 5'b0_1100;
            7'b1000010: res = 5'b0_1101;
            7'b0110000: res = 5'b0_1110;
            7'b0111000: res = 5'b0_1111;
            default:    res = 5'b1_0000;
        endcase
        return res;
    endfunction

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic [W-1:0]    asm_r;
    logic            ferr_r;

    logic [4:0]      dec_s;
    logic [3:0]      dig_s;
    logic            bad_s;
    logic [W-1:0]    asm_ins_s;
    logic            last_s;

    // Decode the incoming code and form the assembly value with it inserted at idx.
    always_comb begin
        dec_s     = seg_decode(seg_in);
        dig_s     = dec_s[3:0];
        bad_s     = dec_s[4];
        asm_ins_s = asm_r;
        asm_ins_s[{idx_r, 2'b00} +: 4] = dig_s;
        last_s    = (idx_r == IW'(DIGITS - 1));
    end

    // Frame-collection FSM with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            asm_r      <= '0;
            ferr_r     <= 1'b0;
            word       <= '0;
            err        <= 1'b0;
            word_valid <= 1'b0;
            abort      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            abort      <= 1'b0;
            if (seg_valid && seg_first) begin
                // A first digit always restarts; any partial frame is thrown away.
                abort  <= (state_r == COLLECT);
                asm_r  <= W'(dig_s);
                ferr_r <= bad_s;
                if (DIGITS == 1) begin
                    word       <= W'(dig_s);
                    err        <= bad_s;
                    word_valid <= 1'b1;
                    state_r    <= IDLE;
                    idx_r      <= '0;
                    busy       <= 1'b0;
                end else begin
                    state_r <= COLLECT;
                    idx_r   <= IW'(1);
                    busy    <= 1'b1;
                end
            end else if (seg_valid && (state_r == COLLECT)) begin
                asm_r  <= asm_ins_s;
                ferr_r <= ferr_r | bad_s;
                if (last_s) begin
                    word       <= asm_ins_s;
                    err        <= ferr_r | bad_s;
                    word_valid <= 1'b1;
                    state_r    <= IDLE;
                    idx_r      <= '0;
                    busy       <= 1'b0;
                end else begin
                    idx_r <= idx_r + IW'(1);
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_seg7_word_reader.sv
// Randomised and directed bench for seg7_word_reader (DIGITS=4) against a
// queue-based frame model.
module tb_seg7_word_reader;

    localparam logic [6:0] TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk;
    logic        aclr;
    logic [0:6]  seg_in;
    logic        seg_valid;
    logic        seg_first;
    logic [15:0] word;
    logic        word_valid;
    logic        err;
    logic        abort;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    int          q_digs[$];
    bit          q_err;
    logic [15:0] exp_word;
    logic        exp_vld, exp_err, exp_abort, exp_busy;

    seg7_word_reader #(.DIGITS(4)) dut (
        .clk        (clk),
        .aclr       (aclr),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .seg_first  (seg_first),
        .word       (word),
        .word_valid (word_valid),
        .err        (err),
        .abort      (abort),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        q_digs.delete();
        q_err     = 1'b0;
        exp_word  = 16'h0000;
        exp_vld   = 1'b0;
        exp_err   = 1'b0;
        exp_abort = 1'b0;
        exp_busy  = 1'b0;
    endtask

    task automatic decode(input logic [6:0] c, output int d, output bit e);
        d = 0;
        e = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (TBL[k] == c) begin
                d = k;
                e = 1'b0;
            end
        end
    endtask

    // Frame model: a queue of digits; a completed frame is the sum of digit<<4k.
    task automatic model_step(input bit v, input bit f, input logic [6:0] code);
        int d;
        bit e;
        exp_vld   = 1'b0;
        exp_abort = 1'b0;
        if (v) begin
            decode(code, d, e);
            if (f) begin
                exp_abort = (q_digs.size() > 0);
                q_digs.delete();
                q_digs.push_back(d);
                q_err = e;
            end else if (q_digs.size() > 0) begin
                q_digs.push_back(d);
                q_err = q_err | e;
            end
            if (q_digs.size() == 4) begin
                exp_word = 16'h0000;
                for (int k = 0; k < 4; k++) exp_word = exp_word + (16'(q_digs[k]) << (4 * k));
                exp_err = q_err;
                exp_vld = 1'b1;
                q_digs.delete();
            end
        end
        exp_busy = (q_digs.size() > 0);
    endtask

    task automatic step(input bit v, input bit f, input logic [6:0] code);
        @(negedge clk);
        seg_valid = v;
        seg_first = f;
        seg_in    = code;
        @(posedge clk);
        model_step(v, f, code);
        #1;
        seg_valid = 1'b0;
        seg_first = 1'b0;
    endtask

    task automatic test_reset();
        aclr = 1'b0;
        seg_valid = 1'b0;
        seg_first = 1'b0;
        seg_in = 7'b1111111;
        model_reset();
        #12;
        n_cmp++;
        if ({word, word_valid, err, abort, busy} !== 20'h00000) begin
            n_fail++;
            $display("FAIL reset: got word=%h v=%b e=%b a=%b b=%b, want all zero", word, word_valid, err, abort, busy);
        end
        @(negedge clk);
        aclr = 1'b1;
    endtask

    task automatic test_back_to_back();
        int d[4] = '{4, 3, 2, 1};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1'b1, i == 0, TBL[d[i]]);
            else step(1'b0, 1'b0, 7'b0000000);
            n_cmp++;
            if ({word, word_valid, err, abort, busy} !== {exp_word, exp_vld, exp_err, exp_abort, exp_busy}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i, word, word_valid, err, abort, busy,
                         exp_word, exp_vld, exp_err, exp_abort, exp_busy);
            end
            if (i == 3) begin
                n_cmp++;
                if ({word, err, word_valid} !== {16'h1234, 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL b2b_word: got %h err=%b v=%b want 1234 err=0 v=1", word, err, word_valid);
                end
            end
        end
    endtask

    task automatic test_gaps();
        int d[4] = '{15, 14, 13, 12};
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 3; g++) begin
                if (g == 0) step(1'b1, i == 0, TBL[d[i]]);
                else step(1'b0, 1'b0, TBL[d[i]]);
                if (word_valid === 1'b1) pulses++;
                n_cmp++;
                if ({word, word_valid, err, abort, busy} !== {exp_word, exp_vld, exp_err, exp_abort, exp_busy}) begin
                    n_fail++;
                    $display("FAIL gaps[%0d.%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i, g, word, word_valid, err, abort, busy,
                             exp_word, exp_vld, exp_err, exp_abort, exp_busy);
                end
            end
        end
        n_cmp++;
        if (pulses != 1 || word !== 16'hCDEF) begin
            n_fail++;
            $display("FAIL gaps_word: got %h pulses=%0d want cdef pulses=1", word, pulses);
        end
    endtask

    task automatic test_error();
        logic [6:0] c[8];
        c = '{TBL[5], 7'b1111111, TBL[6], TBL[7], TBL[0], TBL[0], TBL[0], TBL[0]};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i % 4) == 0, c[i]);
            n_cmp++;
            if ({word, word_valid, err, abort, busy} !== {exp_word, exp_vld, exp_err, exp_abort, exp_busy}) begin
                n_fail++;
                $display("FAIL error[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i, word, word_valid, err, abort, busy,
                         exp_word, exp_vld, exp_err, exp_abort, exp_busy);
            end
            if (i == 3 || i == 7) begin
                n_cmp++;
                if ({word, err, word_valid} !== ((i == 3) ? {16'h7605, 1'b1, 1'b1} : {16'h0000, 1'b0, 1'b1})) begin
                    n_fail++;
                    $display("FAIL error_word[%0d]: got %h err=%b v=%b", i, word, err, word_valid);
                end
            end
        end
    endtask

    task automatic test_abort();
        int  d[6] = '{1, 2, 9, 10, 11, 12};
        bit  f[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int  aborts = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, f[i], TBL[d[i]]);
            if (abort === 1'b1) aborts++;
            n_cmp++;
            if ({word, word_valid, err, abort, busy} !== {exp_word, exp_vld, exp_err, exp_abort, exp_busy}) begin
                n_fail++;
                $display("FAIL abort[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i, word, word_valid, err, abort, busy,
                         exp_word, exp_vld, exp_err, exp_abort, exp_busy);
            end
        end
        n_cmp++;
        if (aborts != 1 || word !== 16'hCBA9 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_word: got %h err=%b aborts=%0d want cba9 err=0 aborts=1", word, err, aborts);
        end
    endtask

    task automatic test_idle_and_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step(1'b1, 1'b0, TBL[3]);
            else step(1'b1, i == 3, TBL[8]);
            n_cmp++;
            if ({word, word_valid, err, abort, busy} !== {exp_word, exp_vld, exp_err, exp_abort, exp_busy}) begin
                n_fail++;
                $display("FAIL idle[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i, word, word_valid, err, abort, busy,
                         exp_word, exp_vld, exp_err, exp_abort, exp_busy);
            end
        end
        @(negedge clk);
        #2 aclr = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({word, word_valid, err, abort, busy} !== 20'h00000) begin
            n_fail++;
            $display("FAIL midreset: got word=%h v=%b e=%b a=%b b=%b, want all zero", word, word_valid, err, abort, busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        aclr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, i == 1, TBL[8]);
            n_cmp++;
            if ({word, word_valid, err, abort, busy} !== {exp_word, exp_vld, exp_err, exp_abort, exp_busy}) begin
                n_fail++;
                $display("FAIL postreset[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i, word, word_valid, err, abort, busy,
                         exp_word, exp_vld, exp_err, exp_abort, exp_busy);
            end
        end
        n_cmp++;
        if (word !== 16'h8888 || word_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL postreset_word: got %h v=%b want 8888 v=1", word, word_valid);
        end
    endtask

    task automatic test_random();
        bit v, f;
        logic [6:0] c;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : TBL[$urandom_range(0, 15)];
            step(v, f, c);
            n_cmp++;
            if ({word, word_valid, err, abort, busy} !== {exp_word, exp_vld, exp_err, exp_abort, exp_busy}) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i, word, word_valid, err, abort, busy,
                         exp_word, exp_vld, exp_err, exp_abort, exp_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_error();
        test_abort();
        test_idle_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_word_reader.md
SEG7_WORD_READER -- requirements
Module: seg7_word_reader

Interface
REQ-001 Parameter: DIGITS, default 4, number of 7-segment digits per frame (range 1..8); the word width is W = 4*DIGITS.
REQ-002 Port: clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 Port: aclr  input  1  reset, asynchronous and active-low.
REQ-004 Port: seg_in  input  [0:6]  active-low segment code; bit 0 is segment a and bit 6 is segment g.
REQ-005 Port: seg_valid  input  1  seg_in holds a digit this cycle.
REQ-006 Port: seg_first  input  1  qualifies seg_valid; marks the first (least-significant) digit of a frame.
REQ-007 Port: word  output  [W-1:0]  last completed frame; digit k occupies word[4k+3:4k].
REQ-008 Port: word_valid  output  1  one-cycle pulse when word is updated.
REQ-009 Port: err  output  1  valid with word_valid; 1 if any digit in that frame had an illegal code.
REQ-010 Port: abort  output  1  one-cycle pulse when an incomplete frame is discarded.
REQ-011 Port: busy  output  1  high while a frame is partially collected (COLLECT state).

Function
REQ-012 Each code SHALL be decoded through this exact table (digit:code): 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100, A:0001000, B:1100000, C:0110001, D:1000010, E:0110000, F:0111000.
REQ-013 Any other code SHALL be illegal: the digit is stored as 4'h0 and the frame error flag is set.
REQ-014 The block SHALL implement two states, IDLE and COLLECT, with a digit index idx of width ceil(log2(DIGITS)), minimum 1 bit.
REQ-015 In IDLE, seg_valid=1 with seg_first=1 SHALL store digit 0, clear the frame error, load the error from digit 0, set idx=1 and enter COLLECT.
REQ-016 In IDLE, seg_valid=1 with seg_first=0 SHALL be ignored: no state change and no output pulse.
REQ-017 In COLLECT, seg_valid=1 with seg_first=0 SHALL store the digit at idx, OR its error into the frame error and increment idx.
REQ-018 When the digit at idx = DIGITS-1 is accepted, the block SHALL return to IDLE on the next edge and update word and err.
  - word_valid SHALL pulse on that same edge, i.e. 1 cycle of latency after the last digit is sampled.
REQ-019 In COLLECT, seg_valid=1 with seg_first=1 SHALL pulse abort, discard the partial frame and restart as in REQ-015 with this digit as digit 0, all in the same cycle.
REQ-020 seg_valid=0 SHALL hold all state; there is no timeout, and gaps between digits are unlimited.
REQ-021 With DIGITS=1, a seg_first digit in IDLE SHALL complete the frame immediately: word_valid pulses, the state stays IDLE and busy stays 0.
REQ-022 word and err SHALL hold their values between frames and change only on completion.
  - Partial digits SHALL be kept in a separate shift/assembly register, never in word.
REQ-023 word_valid and abort SHALL never assert in the same cycle, and neither SHALL be high for more than one cycle per event.

Reset
REQ-024 When aclr=0, the block SHALL immediately go to IDLE with idx=0, word=0, err=0, word_valid=0, abort=0, busy=0 and the assembly register and frame error cleared.
REQ-025 Reset during COLLECT SHALL discard the partial frame without pulsing abort.
  - After release, the first accepted digit SHALL require seg_first=1.

Verification
REQ-026 DIGITS=4; send codes for 4, 3, 2, 1 (first on 4) with back-to-back seg_valid -> one cycle after the 4th digit: word=16'h1234, err=0, word_valid high 1 cycle, busy then 0.
REQ-027 Send codes F, E, D, C with 2-cycle gaps of seg_valid=0 -> word=16'hCDEF, word_valid pulses once, and busy=1 from the 1st digit until completion.
REQ-028 Send 5, then illegal 1111111, then 6, 7 -> word=16'h7605, err=1 with word_valid; a following clean frame of 0, 0, 0, 0 gives word=16'h0000 and err=0.
REQ-029 Send 1, 2 (first on 1), then seg_first with 9, then A, B, C -> abort pulses once at the 9; the result is word=16'hCBA9 and err=0, and word never shows 1 or 2.
REQ-030 Send non-first digits in IDLE -> no output; then assert aclr=0 mid-frame after 2 digits -> outputs cleared at once, no abort; the next seg_first frame of 8, 8, 8, 8 gives word=16'h8888.
